// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// fulladder
//   Single-bit full adder. It is the only arithmetic element in the serial
//   adder below, which reuses it once per clock.
//
//   Ports
//     A     in   1   addend bit
//     B     in   1   addend bit
//     Cin   in   1   carry in
//     Cout  out  1   carry out
//     Sum   out  1   sum bit
// ---------------------------------------------------------------------------
module fulladder (
   input  logic A,
   input  logic B,
   input  logic Cin,
   output logic Cout,
   output logic Sum
);

   logic half;

   assign half = A ^ B;
   assign Sum  = half ^ Cin;
   assign Cout = (A & B) | (Cin & half);

endmodule

// ---------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial adder sequencer. On an accepted start it captures A, B and Cin,
//   then feeds one bit pair per clock (LSB first) through a single fulladder,
//   shifting result bits into a shift register. After WIDTH cycles the full
//   sum and final carry are published on Sum/Cout together with a one-cycle
//   done pulse. Sum/Cout only ever change on that done cycle.
//
//   Parameters
//     WIDTH  operand/result width in bits, 1..32
//
//   Ports
//     clk    in   1      rising-edge clock
//     rst_n  in   1      synchronous active-low reset
//     start  in   1      request, sampled only while busy=0
//     A      in   WIDTH  operand A, captured on an accepted start
//     B      in   WIDTH  operand B, captured on an accepted start
//     Cin    in   1      carry-in, captured on an accepted start
//     busy   out  1      high while an add is in progress
//     done   out  1      one-cycle pulse, Sum/Cout valid from this cycle
//     Sum    out  WIDTH  registered result, held until next completion
//     Cout   out  1      registered final carry, held like Sum
// ---------------------------------------------------------------------------
module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
);

   // Counter is at least one bit wide so WIDTH=1 still has a legal vector.
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   if (WIDTH < 1 || WIDTH > 32) begin : g_width_check
      $error("serial_adder_ctrl: WIDTH must be in 1..32");
   end

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  sha_q, sha_d;
   logic [WIDTH-1:0]  shb_q, shb_d;
   logic [WIDTH-1:0]  shr_q, shr_d;
   logic              carry_q, carry_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic              cout_q, cout_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              fa_sum;
   logic              fa_cout;
   logic [WIDTH-1:0]  shr_next;

   // The one and only adder; every result bit passes through it.
   fulladder u_fa (
      .A    (sha_q[0]),
      .B    (shb_q[0]),
      .Cin  (carry_q),
      .Cout (fa_cout),
      .Sum  (fa_sum)
   );

   // New sum bit enters at the MSB so that after WIDTH shifts bit 0 of the
   // operands has travelled down to bit 0 of the result.
   if (WIDTH == 1) begin : g_shr_w1
      assign shr_next = fa_sum;
   end else begin : g_shr_wn
      assign shr_next = {fa_sum, shr_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d = state_q;
      sha_d   = sha_q;
      shb_d   = shb_q;
      shr_d   = shr_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               sha_d   = A;
               shb_d   = B;
               carry_d = Cin;
               cnt_d   = '0;
               shr_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end

         RUN: begin
            shr_d   = shr_next;
            sha_d   = sha_q >> 1;
            shb_d   = shb_q >> 1;
            carry_d = fa_cout;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               sum_d   = shr_next;
               cout_d  = fa_cout;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               // Park the counter instead of letting it wrap at 2**CW.
               cnt_d   = '0;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sha_q   <= '0;
         shb_q   <= '0;
         shr_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sha_q   <= sha_d;
         shb_q   <= shb_d;
         shr_q   <= shr_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign Sum  = sum_q;
   assign Cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: one WIDTH=8 instance and one WIDTH=1 instance
// on a shared clock, checked against plain integer addition.
module tb_serial_adder_ctrl;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // WIDTH=8 instance
   logic       rst_n8, start8, cin8, busy8, done8, cout8;
   logic [7:0] a8, b8, sum8;
   // WIDTH=1 instance
   logic       rst_n1, start1, cin1, busy1, done1, cout1;
   logic [0:0] a1, b1, sum1;

   int errors = 0;
   int checks = 0;

   // Reference view of what Sum/Cout of the 8-bit unit should be holding.
   logic [7:0] prev_sum;
   logic       prev_cout;

   serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n8),
      .start (start8),
      .A     (a8),
      .B     (b8),
      .Cin   (cin8),
      .busy  (busy8),
      .done  (done8),
      .Sum   (sum8),
      .Cout  (cout8)
   );

   serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n1),
      .start (start1),
      .A     (a1),
      .B     (b1),
      .Cin   (cin1),
      .busy  (busy1),
      .done  (done1),
      .Sum   (sum1),
      .Cout  (cout1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n8 = 1'b0; rst_n1 = 1'b0;
      start8 = 1'b0; start1 = 1'b0;
      a8 = 8'hA7; b8 = 8'h3C; cin8 = 1'b1;
      a1 = 1'b1;  b1 = 1'b1;  cin1 = 1'b1;
      step(); step();
      checks++;
      if ({busy8, done8, sum8, cout8} !== 11'd0) begin
         errors++;
         $display("FAIL reset8 got busy=%b done=%b sum=%h cout=%b want all zero",
                  busy8, done8, sum8, cout8);
      end
      checks++;
      if ({busy1, done1, sum1, cout1} !== 4'd0) begin
         errors++;
         $display("FAIL reset1 got busy=%b done=%b sum=%h cout=%b want all zero",
                  busy1, done1, sum1, cout1);
      end
      rst_n8 = 1'b1; rst_n1 = 1'b1;
      step();
      checks++;
      if ({busy8, done8} !== 2'b00) begin
         errors++;
         $display("FAIL idle8 got busy=%b done=%b want 0 0", busy8, done8);
      end
      prev_sum  = 8'h00;
      prev_cout = 1'b0;
   endtask

   // One complete add on the 8-bit unit. Starts in the current cycle (which
   // may be a done cycle), returns in the cycle where done is seen.
   task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic cin);
      logic [8:0] expv;
      int         lat;
      expv = {1'b0, a} + {1'b0, b} + 9'(cin);
      a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
      step();
      start8 = 1'b0;
      // Operand wiggle during the add must not matter.
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      lat = 0;
      while (done8 !== 1'b1 && lat <= 20) begin
         checks++;
         if (busy8 !== 1'b1) begin
            errors++;
            $display("FAIL busy_during_add got %b want 1 (cycle %0d)", busy8, lat);
         end
         checks++;
         if ({cout8, sum8} !== {prev_cout, prev_sum}) begin
            errors++;
            $display("FAIL result_hold got %h want %h (cycle %0d)",
                     {cout8, sum8}, {prev_cout, prev_sum}, lat);
         end
         step();
         lat++;
      end
      checks++;
      if (lat != 8) begin
         errors++;
         $display("FAIL latency got %0d want 8", lat);
      end
      checks++;
      if ({cout8, sum8} !== expv) begin
         errors++;
         $display("FAIL add %h+%h+%b got %h want %h", a, b, cin, {cout8, sum8}, expv);
      end
      checks++;
      if (busy8 !== 1'b0) begin
         errors++;
         $display("FAIL busy_at_done got %b want 0", busy8);
      end
      prev_sum  = expv[7:0];
      prev_cout = expv[8];
   endtask

   task automatic idle8();
      step();
      checks++;
      if (done8 !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse_width got %b want 0", done8);
      end
   endtask

   task automatic test_directed();
      add8(8'h3C, 8'h42, 1'b0); idle8();
      add8(8'hFF, 8'h01, 1'b0); idle8();
      add8(8'hA5, 8'h5A, 1'b1); idle8();
      add8(8'h00, 8'h00, 1'b0); idle8();
      add8(8'hFF, 8'hFF, 1'b1); idle8();
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++) begin
         add8(8'($urandom), 8'($urandom), 1'($urandom));
         idle8();
      end
   endtask

   task automatic test_ignore_start();
      logic [8:0] expv;
      int         ndone;
      int         done_at;
      expv = {1'b0, 8'h12} + {1'b0, 8'h34} + 9'd1;
      a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
      step();
      ndone = 0; done_at = -1;
      for (int i = 1; i <= 12; i++) begin
         start8 = (i == 3 || i == 5);
         a8 = 8'hF0 + 8'(i); b8 = 8'h0F; cin8 = 1'b1;
         step();
         if (done8 === 1'b1) begin
            ndone++;
            done_at = i;
         end
      end
      start8 = 1'b0;
      checks++;
      if (ndone != 1 || done_at != 8) begin
         errors++;
         $display("FAIL ignore_start got %0d dones at edge %0d want 1 at edge 8",
                  ndone, done_at);
      end
      checks++;
      if ({cout8, sum8} !== expv) begin
         errors++;
         $display("FAIL ignore_start_result got %h want %h", {cout8, sum8}, expv);
      end
      prev_sum  = expv[7:0];
      prev_cout = expv[8];
   endtask

   task automatic test_reset_mid();
      int ndone;
      a8 = 8'h77; b8 = 8'h99; cin8 = 1'b1; start8 = 1'b1;
      step();
      start8 = 1'b0;
      for (int i = 1; i < 4; i++) step();
      rst_n8 = 1'b0;
      step();
      rst_n8 = 1'b1;
      checks++;
      if ({busy8, done8, sum8, cout8} !== 11'd0) begin
         errors++;
         $display("FAIL reset_mid got busy=%b done=%b sum=%h cout=%b want all zero",
                  busy8, done8, sum8, cout8);
      end
      ndone = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (done8 === 1'b1) ndone++;
      end
      checks++;
      if (ndone != 0) begin
         errors++;
         $display("FAIL reset_mid_no_done got %0d dones want 0", ndone);
      end
      prev_sum  = 8'h00;
      prev_cout = 1'b0;
      add8(8'hC3, 8'h5E, 1'b0);
      idle8();
   endtask

   task automatic test_back_to_back();
      // Second start is issued in the done cycle of the first.
      add8(8'h80, 8'h80, 1'b0);
      add8(8'h01, 8'h02, 1'b1);
      add8(8'($urandom), 8'($urandom), 1'($urandom));
      idle8();
   endtask

   task automatic test_width1();
      logic [1:0] expv;
      for (int i = 0; i < 8; i++) begin
         a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i);
         expv = 2'(a1) + 2'(b1) + 2'(cin1);
         start1 = 1'b1;
         step();
         start1 = 1'b0;
         checks++;
         if ({busy1, done1} !== 2'b10) begin
            errors++;
            $display("FAIL w1_running got busy=%b done=%b want 1 0", busy1, done1);
         end
         step();
         checks++;
         if ({busy1, done1} !== 2'b01) begin
            errors++;
            $display("FAIL w1_done got busy=%b done=%b want 0 1", busy1, done1);
         end
         checks++;
         if ({cout1, sum1} !== expv) begin
            errors++;
            $display("FAIL w1_add %b%b%b got %b want %b", a1, b1, cin1,
                     {cout1, sum1}, expv);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_width1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard stop so a wedged run still terminates.
   initial begin
      #200000;
      $display("FAIL watchdog expired got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
